// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcode map, ALU operation
// codes, datapath select encodings and the state encodings exposed on StateOut.
package mips_ctrl_pkg;

  localparam int OP_W     = 6;
  localparam int CLASS_HI = 5;
  localparam int CLASS_LO = 4;

  localparam logic [1:0] CLASS_R = 2'b00;
  localparam logic [1:0] CLASS_I = 2'b01;

  localparam logic [OP_W-1:0] OP_LW   = 6'b100000;
  localparam logic [OP_W-1:0] OP_SW   = 6'b100001;
  localparam logic [OP_W-1:0] OP_BZ   = 6'b100010;
  localparam logic [OP_W-1:0] OP_BNZ  = 6'b100011;
  localparam logic [OP_W-1:0] OP_J    = 6'b100100;
  localparam logic [OP_W-1:0] OP_NOP  = 6'b110000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  // ALU operation set shared with the datapath ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1001;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUREG = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WAIT = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_HALT     = 4'd11
  } state_e;

  // One-hot instruction class; all-zero means the opcode is undefined
  typedef struct packed {
    logic r_type;
    logic i_type;
    logic lw;
    logic sw;
    logic bz;
    logic bnz;
    logic jmp;
    logic nop;
    logic halt;
  } op_class_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decode: one-hot instruction class, the ALU operation
// that class implies, and the undefined-opcode flag.
module ctrl_opdecode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output op_class_t       op_class,
  output logic [3:0]      alu_op,
  output logic            illegal
);

  always_comb begin
    // NOTE: defaulting every output before the case keeps this block free of latches.
    op_class = '0;
    case (opcode[CLASS_HI:CLASS_LO])
      CLASS_R: op_class.r_type = 1'b1;
      CLASS_I: op_class.i_type = 1'b1;
      default: begin
        case (opcode)
          OP_LW:   op_class.lw   = 1'b1;
          OP_SW:   op_class.sw   = 1'b1;
          OP_BZ:   op_class.bz   = 1'b1;
          OP_BNZ:  op_class.bnz  = 1'b1;
          OP_J:    op_class.jmp  = 1'b1;
          OP_NOP:  op_class.nop  = 1'b1;
          OP_HALT: op_class.halt = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  assign illegal = (op_class == '0);
  assign alu_op  = (op_class.r_type || op_class.i_type) ? opcode[3:0] : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction-sequencing FSM and control-word decode for the 32-bit
// datapath. Define CTRL_MEM_WAIT_EN to insert MEM_WAIT for synchronous-read memory.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [OP_W-1:0] OpcodeIn,
  output logic            PCWrite,
  output logic [1:0]      Branch,
  output logic [1:0]      PCSrc,
  output logic            IRWrite,
  output logic            SN,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [3:0]      ALUOp,
  output logic            RegWrite,
  output logic            RegSrc,
  output logic            MemWrite,
  output logic            Halted,
  output logic            IllegalOp,
  output logic [3:0]      StateOut
);

  state_e    state;
  op_class_t op_class;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;

  ctrl_opdecode u_opdecode (
    .opcode   (OpcodeIn),
    .op_class (op_class),
    .alu_op   (dec_alu_op),
    .illegal  (dec_illegal)
  );

  // NOTE: state is sequential, so it is only ever assigned with <=.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          if (op_class.r_type)                  state <= ST_EXEC_R;
          else if (op_class.i_type)             state <= ST_EXEC_I;
          else if (op_class.lw)                 state <= ST_MEM_RD;
          else if (op_class.sw)                 state <= ST_MEM_WR;
          else if (op_class.bz || op_class.bnz) state <= ST_BRANCH;
          else if (op_class.jmp)                state <= ST_JUMP;
          else if (op_class.halt)               state <= ST_HALT;
          else if (op_class.nop)                state <= ST_FETCH;
          else                                  state <= ILLEGAL_HALTS ? ST_HALT : ST_FETCH;
        end
        ST_EXEC_R, ST_EXEC_I: state <= ST_ALU_WB;
`ifdef CTRL_MEM_WAIT_EN
        ST_MEM_RD:   state <= ST_MEM_WAIT;
        ST_MEM_WAIT: state <= ST_MEM_WB;
`else
        ST_MEM_RD:   state <= ST_MEM_WB;
`endif
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  // Outputs follow the state register and the (stable, post-fetch) opcode
  always_comb begin
    PCWrite   = 1'b0;
    Branch    = 2'b00;
    PCSrc     = PCSRC_ALU;
    IRWrite   = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ALUOp     = ALU_ADD;
    RegWrite  = 1'b0;
    RegSrc    = 1'b0;
    MemWrite  = 1'b0;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    case (state)
      ST_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_ONE;
      end
      ST_DECODE: IllegalOp = dec_illegal;
      ST_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = dec_alu_op;
      end
      ST_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = dec_alu_op;
      end
      ST_ALU_WB: RegWrite = 1'b1;
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        RegSrc   = 1'b1;
      end
      ST_MEM_WR: MemWrite = 1'b1;
      ST_BRANCH: begin
        ALUSrcB = SRCB_IMM;
        Branch  = {op_class.bnz, op_class.bz};
      end
      ST_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      ST_HALT: Halted = 1'b1;
      default: ;
    endcase
    // Reset aborts the current instruction before any strobe reaches the datapath
    if (Reset) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      Branch    = 2'b00;
      Halted    = 1'b0;
      IllegalOp = 1'b0;
    end
  end

  assign SN       = (state != ST_FETCH) && (op_class.r_type || op_class.i_type);
  assign StateOut = state;

endmodule
